dac_spi_responder: RTL and testbench
====================================

// Module: dac_spi_responder
// PURPOSE
//  Responder (slave) end of the 32-bit DAC SPI link: a 4-channel, 12-bit DAC model driven by the DAC master.
//  Oversamples SCK/CS/MOSI in the CLK50MHZ domain, shifts in frames, decodes command/address/data and
//  updates per-channel input/DAC registers. Echoes the previous frame on DAC_OUT.
//  Used in benches and as the loopback target on-chip.
// PARAMETERS
//  WIDTH        32  frame length in bits; only exactly-WIDTH frames are executed
//  SYNC_STAGES  2   synchronizer flops on SPI_SCK, DAC_CS, SPI_MOSI, DAC_CLR (>=2)
// PORTS
//  CLK50MHZ     in   1   system clock; SCK high and low phases each >= SYNC_STAGES+1 cycles
//  RST          in   1   synchronous, active-high reset
//  SPI_SCK      in   1   SPI clock from master, idle low, MOSI sampled on rising edge
//  DAC_CS       in   1   chip select, active low, frames a transfer
//  SPI_MOSI     in   1   serial data in, MSB first
//  DAC_CLR      in   1   asynchronous-to-clk clear input, active low (synchronized internally)
//  DAC_OUT      out  1   serial echo of shift register MSB, changes after SCK falling edge
//  dac_value    out  48  {ch3,ch2,ch1,ch0} 12-bit DAC registers (analog output values)
//  rx_command   out  4   command field of last executed frame
//  rx_address   out  4   address field of last executed frame
//  rx_data      out  12  data field of last executed frame
//  frame_valid  out  1   1-cycle pulse: WIDTH-bit frame accepted and executed
//  frame_error  out  1   1-cycle pulse: CS rose with bit count != WIDTH; frame discarded
// BEHAVIOUR
//  Reset: shift reg, bit_cnt, input regs, dac_value, rx_* = 0; DAC_OUT=0; pulses=0; sync flops=idle (SCK=0,CS=1,CLR=1).
//  Edge detect on synchronized signals; all actions one cycle after the synchronized edge.
//  States: IDLE (CS high) -> SHIFT on CS fall (bit_cnt:=0) -> back to IDLE on CS rise.
//  SHIFT, SCK rise: sr <= {sr[WIDTH-2:0], mosi}; bit_cnt += 1, saturating at 63.
//  SHIFT, SCK fall: DAC_OUT <= sr[WIDTH-1]. In IDLE DAC_OUT holds its value.
//   => with no extra clocks DAC_OUT streams the previous frame; master readback of frame N = frame N-1.
//  CS rise, bit_cnt==WIDTH: frame_valid pulse; fields sr = {8'hxx, cmd, addr, data[11:0], 4'hx}.
//  CS rise, bit_cnt!=WIDTH (incl. 0): frame_error pulse (none if bit_cnt==0), no register change, sr kept.
//  Latency: frame_valid, rx_*, and register updates same cycle, SYNC_STAGES+1 clocks after pin CS rise.
//  Commands (addr 0..3 = channel, 4'hF = all channels, other addr = no channel affected):
//   4'h0 write input reg(addr);  4'h1 update dac(addr) <= input(addr);
//   4'h2 write input reg(addr), then update all dac <= input; 4'h3 write+update addr;
//   4'hF no-op; any other command no-op (still frame_valid, rx_* updated).
//  Write and update on the same frame: dac takes the newly written value.
//  DAC_CLR low (synchronized): input regs and dac_value forced 0 every cycle; frames still shift
//   and pulse frame_valid but register writes are suppressed; rx_* still update.
//  RST mid-frame: everything to reset values; a CS still low after reset is ignored until it rises
//   (no frame_error for that partial frame).
//  SCK edges while CS high ignored. CS glitch shorter than SYNC_STAGES cycles: behaviour undefined.
// TESTING
//  Frame 0x80_3_0_ABC_1 (cmd3,addr0) -> frame_valid once, dac_value[11:0]=12'hABC, others 0.
//  0x80_0_F_555_1 then 0x80_1_2_000_1 -> after 1st dac_value=0; after 2nd ch2=12'h555, ch0/1/3=0.
//  Frames A=0x80_3_1_123_1, B=0x80_3_2_456_1 -> DAC_OUT bits during B equal A MSB-first, i.e. readback 0x80311231.
//  31-bit and 33-bit frames -> frame_error each, no frame_valid, dac_value unchanged.
//  DAC_CLR low during cmd3 write 0xFFF ch1 -> dac_value stays 0, frame_valid=1, rx_data=12'hFFF.
//  RST pulse after 16 bits, CS held low then raised -> no pulses; next full frame executes normally.

Source files
------------

// File: rtl/dac_spi_responder.sv
// dac_spi_responder: SPI responder modelling a 4-channel 12-bit DAC with frame decode and echo of the previous frame
`timescale 1ns/1ps
module dac_spi_responder #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        SPI_SCK,
    input  logic        DAC_CS,
    input  logic        SPI_MOSI,
    input  logic        DAC_CLR,
    output logic        DAC_OUT,
    output logic [47:0] dac_value,
    output logic [3:0]  rx_command,
    output logic [3:0]  rx_address,
    output logic [11:0] rx_data,
    output logic        frame_valid,
    output logic        frame_error
);
    localparam logic [5:0] FULL = 6'(WIDTH);
    localparam logic [3:0] ARM  = 4'(SYNC_STAGES);

    typedef enum logic [1:0] {WAIT, IDLE, SHIFT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q, clr_q;
    logic                   sck_s, cs_s, mosi_s, clr_s;
    logic                   sck_d, cs_d;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [3:0]             arm_cnt;
    logic [WIDTH-1:0]       sr;
    logic [5:0]             bit_cnt;
    logic                   do_start, do_shift, do_out, do_exec, do_err;
    logic [3:0]             f_cmd, f_addr;
    logic [11:0]            f_data;
    logic [3:0][11:0]       in_reg, dac_reg, in_nxt, dac_nxt;
    logic [3:0]             sel;

    assign sck_s     = sck_q[SYNC_STAGES-1];
    assign cs_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign clr_s     = clr_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign f_cmd     = sr[23:20];
    assign f_addr    = sr[19:16];
    assign f_data    = sr[15:4];
    assign dac_value = dac_reg;

    // Synchronize the SPI pins and keep one delayed copy for edge detection
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            clr_q  <= '1;
            sck_d  <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], SPI_SCK};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], DAC_CS};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], SPI_MOSI};
            clr_q  <= {clr_q[SYNC_STAGES-2:0], DAC_CLR};
            sck_d  <= sck_s;
            cs_d   <= cs_s;
        end
    end

    // State register; after reset CS must be seen high once the synchronizer has flushed
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state   <= WAIT;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= (state != WAIT || !cs_s) ? '0 : (arm_cnt == ARM ? arm_cnt : arm_cnt + 4'd1);
        end
    end

    // Next-state: a partial frame left over from reset is dropped in WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    state_nxt = (cs_s && arm_cnt == ARM) ? IDLE : WAIT;
            IDLE:    state_nxt = cs_fall ? SHIFT : IDLE;
            SHIFT:   state_nxt = cs_rise ? IDLE : SHIFT;
            default: state_nxt = WAIT;
        endcase
    end

    // Datapath strobes decoded from state and synchronized edges
    always_comb begin
        do_start = state == IDLE && cs_fall;
        do_shift = state == SHIFT && !cs_rise && sck_rise;
        do_out   = state == SHIFT && sck_fall;
        do_exec  = state == SHIFT && cs_rise && bit_cnt == FULL;
        do_err   = state == SHIFT && cs_rise && bit_cnt != FULL && bit_cnt != 6'd0;
    end

    // Command decode: write selected inputs first so a same-frame update sees the new value
    always_comb begin
        in_nxt  = in_reg;
        dac_nxt = dac_reg;
        sel     = '0;
        for (int i = 0; i < 4; i++) begin
            sel[i] = f_addr == i[3:0] || f_addr == 4'hF;
            if (do_exec && sel[i] && (f_cmd == 4'h0 || f_cmd == 4'h2 || f_cmd == 4'h3))
                in_nxt[i] = f_data;
        end
        for (int i = 0; i < 4; i++)
            if (do_exec && (((f_cmd == 4'h1 || f_cmd == 4'h3) && sel[i]) || f_cmd == 4'h2))
                dac_nxt[i] = in_nxt[i];
        if (!clr_s) begin
            in_nxt  = '0;
            dac_nxt = '0;
        end
    end

    // Shift register, bit counter, echo output, received fields and channel registers
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            sr          <= '0;
            bit_cnt     <= '0;
            DAC_OUT     <= 1'b0;
            rx_command  <= '0;
            rx_address  <= '0;
            rx_data     <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            in_reg      <= '0;
            dac_reg     <= '0;
        end else begin
            frame_valid <= do_exec;
            frame_error <= do_err;
            in_reg      <= in_nxt;
            dac_reg     <= dac_nxt;
            if (do_start)
                bit_cnt <= '0;
            else if (do_shift) begin
                sr      <= {sr[WIDTH-2:0], mosi_s};
                bit_cnt <= bit_cnt + {5'd0, bit_cnt != 6'd63};
            end
            if (do_out)
                DAC_OUT <= sr[WIDTH-1];
            if (do_exec) begin
                rx_command <= f_cmd;
                rx_address <= f_addr;
                rx_data    <= f_data;
            end
        end
    end
endmodule

// File: tb/tb_dac_spi_responder.sv
// tb_dac_spi_responder: drives SPI frames into dac_spi_responder and checks against a channel-register model
`timescale 1ns/1ps
module tb_dac_spi_responder;
    localparam int PH = 4;

    logic        clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0, clr = 1'b1;
    logic        dout, fv, fe;
    logic [47:0] dac_value;
    logic [3:0]  rx_command, rx_address;
    logic [11:0] rx_data;

    int          checks = 0, errors = 0, nv = 0, ne = 0;
    logic [31:0] m_sr = '0, sr_prev, rb;
    logic [11:0] m_in [4];
    logic [11:0] m_dac [4];
    logic [3:0]  m_cmd, m_addr;
    logic [11:0] m_data;

    dac_spi_responder dut (
        .CLK50MHZ(clk), .RST(rst), .SPI_SCK(sck), .DAC_CS(cs), .SPI_MOSI(mosi), .DAC_CLR(clr),
        .DAC_OUT(dout), .dac_value(dac_value), .rx_command(rx_command), .rx_address(rx_address),
        .rx_data(rx_data), .frame_valid(fv), .frame_error(fe)
    );

    always #10 clk = ~clk;

    // Count every pulse cycle so stuck or doubled pulses show up in the per-frame totals
    always @(negedge clk) begin
        if (fv) nv++;
        if (fe) ne++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [47:0] m_pack();
        return {m_dac[3], m_dac[2], m_dac[1], m_dac[0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_in[i]  = '0;
            m_dac[i] = '0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_sr   = '0;
        m_cmd  = '0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_exec(input logic [31:0] w);
        m_cmd  = w[23:20];
        m_addr = w[19:16];
        m_data = w[15:4];
        if (clr) begin
            if (m_cmd == 4'h0 || m_cmd == 4'h2 || m_cmd == 4'h3)
                for (int i = 0; i < 4; i++)
                    if (m_addr == i || m_addr == 4'hF) m_in[i] = m_data;
            if (m_cmd == 4'h1 || m_cmd == 4'h3)
                for (int i = 0; i < 4; i++)
                    if (m_addr == i || m_addr == 4'hF) m_dac[i] = m_in[i];
            if (m_cmd == 4'h2)
                for (int i = 0; i < 4; i++) m_dac[i] = m_in[i];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        model_reset();
        chk("rst_dac", dac_value, 48'd0);
        chk("rst_rx", {rx_command, rx_address, rx_data}, 20'd0);
        chk("rst_dout", dout, 1'b0);
        chk("rst_pulses", {fv, fe}, 2'b00);
        cyc(8);
    endtask

    task automatic drive_bits(input logic [63:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            mosi = w[n-1-k];
            cyc(PH);
            if (k < 32) rb = {rb[30:0], dout};
            sck = 1'b1;
            cyc(PH);
            sck = 1'b0;
            m_sr = {m_sr[30:0], w[n-1-k]};
        end
    endtask

    task automatic frame(input logic [63:0] w, input int n);
        int nv0, ne0;
        logic ok;
        ok      = n == 32;
        sr_prev = m_sr;
        rb      = '0;
        nv0     = nv;
        ne0     = ne;
        cs = 1'b0;
        cyc(PH);
        drive_bits(w, n);
        cyc(PH);
        cs = 1'b1;
        cyc(2);
        chk("early_pulse", {fv, fe}, 2'b00);
        cyc(1);
        chk("frame_valid", fv, ok);
        chk("frame_error", fe, !ok && n != 0);
        if (ok) model_exec(w[31:0]);
        cyc(PH);
        chk("valid_count", nv - nv0, ok);
        chk("error_count", ne - ne0, !ok && n != 0);
        if (n > 0) chk("readback", rb, n >= 32 ? sr_prev : sr_prev >> (32 - n));
        chk("dac_value", dac_value, m_pack());
        chk("rx_fields", {rx_command, rx_address, rx_data}, {m_cmd, m_addr, m_data});
    endtask

    task automatic set_clr(input logic v);
        clr = v;
        cyc(6);
        if (!v) model_clear();
        chk("clr_dac", dac_value, m_pack());
    endtask

    initial begin
        logic [63:0] w;
        logic [3:0]  c, a;
        int          n, nv0, ne0, r;
        model_reset();
        do_reset();
        frame(64'h8030ABC1, 32);
        chk("t1_dac", dac_value, 48'h000_000_000_ABC);

        do_reset();
        frame(64'h800F5551, 32);
        chk("t2a_dac", dac_value, 48'd0);
        frame(64'h80120001, 32);
        chk("t2b_dac", dac_value, 48'h000_555_000_000);

        frame(64'h80311231, 32);
        frame(64'h80324561, 32);
        chk("readback_b", rb, 64'h80311231);

        frame({$urandom(), $urandom()}, 31);
        frame({$urandom(), $urandom()}, 33);

        set_clr(1'b0);
        frame(64'h8031FFF1, 32);
        chk("clr_rx_data", rx_data, 12'hFFF);
        chk("clr_dac_zero", dac_value, 48'd0);
        set_clr(1'b1);

        nv0 = nv;
        ne0 = ne;
        cs  = 1'b0;
        cyc(PH);
        drive_bits(64'h8033AAA1, 16);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_reset();
        chk("midrst_dout", dout, 1'b0);
        chk("midrst_dac", dac_value, 48'd0);
        cyc(4);
        drive_bits(64'hA5, 8);
        m_sr = '0;
        cyc(PH);
        cs = 1'b1;
        cyc(10);
        chk("midrst_valid", nv - nv0, 0);
        chk("midrst_error", ne - ne0, 0);
        chk("midrst_rx", {rx_command, rx_address, rx_data}, 20'd0);
        frame(64'h8032BEE1, 32);
        chk("midrst_next", dac_value, 48'h000_BEE_000_000);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 5);
            c = r < 4 ? 4'(r) : (r == 4 ? 4'hF : 4'($urandom()));
            r = $urandom_range(0, 7);
            a = r < 4 ? 4'(r) : (r == 4 ? 4'hF : 4'($urandom()));
            w = {$urandom(), 8'($urandom()), c, a, 12'($urandom()), 4'($urandom())};
            r = $urandom_range(0, 9);
            n = r < 7 ? 32 : (r == 7 ? 31 : (r == 8 ? 33 : int'($urandom_range(0, 40))));
            if ($urandom_range(0, 7) == 0) set_clr(~clr);
            frame(w, n);
        end
        if (!clr) set_clr(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
